dcache_lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 65 ++++++
 rtl/dcache_lsu.sv | 188 ++++++++++++++++++
 tb/tb_dcache_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the dcache load/store unit.
//   lsu_size_t  - CPU access size encoding (BYTE, HALF, WORD; code 3 folds to WORD)
//   lsu_state_t - LSU control states (IDLE, RMW_WR)
//   OFF_W, lane masks and a size-normalising helper used by the top and aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  localparam int          OFF_W          = 2;
  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  // Encoding 3 is not a real size; it behaves as a full word access.
  function automatic lsu_size_t norm_size(input logic [1:0] raw);
    lsu_size_t sz;
    case (raw)
      2'd0:    sz = BYTE;
      2'd1:    sz = HALF;
      default: sz = WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic shared by the load and store paths.
//   rd_word_i  - word read from the cache
//   wdata_i    - right-aligned store data
//   off_i      - byte offset inside the word (little-endian)
//   size_i     - access size
//   unsigned_i - zero-extend instead of sign-extend on loads
//   ext_o      - extracted and extended load result
//   merge_o    - rd_word_i with the addressed lane(s) replaced by wdata_i
import lsu_pkg::*;

module lsu_align (
  input  logic [31:0]      rd_word_i,
  input  logic [31:0]      wdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  lsu_size_t        size_i,
  input  logic             unsigned_i,
  output logic [31:0]      ext_o,
  output logic [31:0]      merge_o
);

  logic [4:0]  shift_s;
  logic [31:0] lane_s;
  logic [31:0] mask_s;

  // Lane selection: bit shift and mask of the addressed byte/halfword.
  always_comb begin
    shift_s = 5'd0;
    mask_s  = 32'hFFFF_FFFF;
    case (size_i)
      BYTE: begin
        shift_s = {off_i, 3'b000};
        mask_s  = BYTE_LANE_MASK << shift_s;
      end
      HALF: begin
        // Halfword lane follows only offset bit 1; bit 0 is zero for aligned halves.
        shift_s = {off_i[1], 4'b0000};
        mask_s  = HALF_LANE_MASK << shift_s;
      end
      default: begin
        shift_s = 5'd0;
        mask_s  = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign lane_s  = rd_word_i >> shift_s;
  assign merge_o = (rd_word_i & ~mask_s) | ((wdata_i << shift_s) & mask_s);

  // Load extension from the lane's top bit unless the access is unsigned.
  always_comb begin
    ext_o = rd_word_i;
    case (size_i)
      BYTE: begin
        if (unsigned_i) ext_o = {24'd0, lane_s[7:0]};
        else            ext_o = {{24{lane_s[7]}}, lane_s[7:0]};
      end
      HALF: begin
        if (unsigned_i) ext_o = {16'd0, lane_s[15:0]};
        else            ext_o = {{16{lane_s[15]}}, lane_s[15:0]};
      end
      default: ext_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/dcache_lsu.sv
// dcache_lsu: load/store unit between the CPU MEM stage and a word-granular
// data cache. Loads and word stores go straight through with zero extra
// latency on a hit; byte/halfword stores do a read-modify-write (read word,
// merge lane, write word in RMW_WR). stall follows cache_miss and covers the
// whole RMW. Misaligned accesses are dropped with misalign=1.
// Ports:
//   clk, rst_n (async, active-low)
//   req_valid/req_we/req_size/req_unsigned/req_addr/req_wdata - CPU request
//   rdata, stall, misalign                                    - CPU response
//   cache_addr/cache_rd_req/cache_wr_req/cache_wr_data         - cache request
//   cache_rd_data, cache_miss                                  - cache response
//   perf_access_cnt, perf_miss_cnt - only when LSU_PERF_CNT_EN is defined
// Optional feature macro: LSU_PERF_CNT_EN (access and miss counters).
import lsu_pkg::*;

module dcache_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_rd_req,
  output logic              cache_wr_req,
  output logic [DATA_W-1:0] cache_wr_data,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]       perf_access_cnt,
  output logic [31:0]       perf_miss_cnt,
`endif
  input  logic [DATA_W-1:0] cache_rd_data,
  input  logic              cache_miss
);

  lsu_state_t         state_q, state_d;
  logic [31:0]        wbuf_q, wbuf_d;
  // Word address of the committed RMW write, so it survives req_* changing.
  logic [ADDR_W-3:0]  waddr_q, waddr_d;

  lsu_size_t          size_s;
  logic [OFF_W-1:0]   off_s;
  logic               misalign_s;
  logic [31:0]        ext_s;
  logic [31:0]        merge_s;
  logic               rd_s, wr_s, stall_s;
  logic [31:0]        wr_data_s, rdata_s;
  logic [ADDR_W-1:0]  addr_s;

  assign size_s     = norm_size(req_size);
  assign off_s      = req_addr[OFF_W-1:0];
  assign misalign_s = req_valid &
                      (((size_s == HALF) & req_addr[0]) |
                       ((size_s == WORD) & (req_addr[1:0] != 2'b00)));

  lsu_align u_align (
    .rd_word_i  (cache_rd_data),
    .wdata_i    (req_wdata),
    .off_i      (off_s),
    .size_i     (size_s),
    .unsigned_i (req_unsigned),
    .ext_o      (ext_s),
    .merge_o    (merge_s)
  );

  // Request steering, stall and next-state logic.
  always_comb begin
    state_d   = state_q;
    wbuf_d    = wbuf_q;
    waddr_d   = waddr_q;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    wr_data_s = 32'd0;
    stall_s   = 1'b0;
    rdata_s   = 32'd0;
    addr_s    = {req_addr[ADDR_W-1:2], 2'b00};
    case (state_q)
      IDLE: begin
        if (req_valid && !misalign_s) begin
          if (!req_we) begin
            rd_s    = 1'b1;
            stall_s = cache_miss;
            if (!cache_miss) rdata_s = ext_s;
            else             rdata_s = 32'd0;
          end else if (size_s == WORD) begin
            wr_s      = 1'b1;
            wr_data_s = req_wdata;
            stall_s   = cache_miss;
          end else begin
            // Sub-word store: read phase always stalls, the write follows next cycle.
            rd_s    = 1'b1;
            stall_s = 1'b1;
            if (!cache_miss) begin
              wbuf_d  = merge_s;
              waddr_d = req_addr[ADDR_W-1:2];
              state_d = RMW_WR;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RMW_WR: begin
        addr_s    = {waddr_q, 2'b00};
        wr_s      = 1'b1;
        wr_data_s = wbuf_q;
        stall_s   = cache_miss;
        if (!cache_miss) state_d = IDLE;
        else             state_d = RMW_WR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request strobes are gated by rst_n so they drop at the instant reset asserts.
  assign cache_rd_req  = rd_s & rst_n;
  assign cache_wr_req  = wr_s & rst_n;
  assign cache_wr_data = wr_data_s;
  assign cache_addr    = addr_s;
  assign stall         = stall_s;
  assign rdata         = rdata_s;
  assign misalign      = misalign_s;

  // FSM state, merge buffer and RMW address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wbuf_q  <= 32'd0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      waddr_q <= waddr_d;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic        miss_seen_q, miss_seen_d;
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        done_s, first_miss_s;

  // Completion: aligned request leaves IDLE unstalled, or the RMW write lands.
  assign done_s = ((state_q == IDLE) & req_valid & ~misalign_s & ~stall_s) |
                  ((state_q == RMW_WR) & ~cache_miss);
  assign first_miss_s = (rd_s | wr_s) & cache_miss & ~miss_seen_q;

  // Counter next-state: one access per completion, one miss per access.
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    miss_seen_d = miss_seen_q;
    if (done_s) acc_cnt_d = acc_cnt_q + 32'd1;
    else        acc_cnt_d = acc_cnt_q;
    if (first_miss_s) miss_cnt_d = miss_cnt_q + 32'd1;
    else              miss_cnt_d = miss_cnt_q;
    if (done_s)            miss_seen_d = 1'b0;
    else if (first_miss_s) miss_seen_d = 1'b1;
    else                   miss_seen_d = miss_seen_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      miss_seen_q <= 1'b0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      miss_seen_q <= miss_seen_d;
    end
  end

  assign perf_access_cnt = acc_cnt_q;
  assign perf_miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_lsu.sv
// tb_dcache_lsu: directed bench for dcache_lsu with a small cache model.
// The cache model misses for a bench-chosen number of cycles after each
// request is issued, reads combinationally and writes on the clock edge.
module tb_dcache_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic [31:0] cache_addr;
  logic        cache_rd_req;
  logic        cache_wr_req;
  logic [31:0] cache_wr_data;
  logic [31:0] cache_rd_data;
  logic        cache_miss;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_access_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  int tests;
  int fails;
  int cyc_cnt;
  int miss_end;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  dcache_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rdata           (rdata),
    .stall           (stall),
    .misalign        (misalign),
    .cache_addr      (cache_addr),
    .cache_rd_req    (cache_rd_req),
    .cache_wr_req    (cache_wr_req),
    .cache_wr_data   (cache_wr_data),
`ifdef LSU_PERF_CNT_EN
    .perf_access_cnt (perf_access_cnt),
    .perf_miss_cnt   (perf_miss_cnt),
`endif
    .cache_rd_data   (cache_rd_data),
    .cache_miss      (cache_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: miss window, combinational read, clocked write/preload.
  assign cache_miss    = (cache_rd_req | cache_wr_req) && (cyc_cnt < miss_end);
  assign cache_rd_data = mem[cache_addr[9:2]];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (cache_wr_req && !cache_miss) mem[cache_addr[9:2]] <= cache_wr_data;
    else if (pre_we)                 mem[pre_idx] <= pre_data;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_idx  = a[9:2];
    pre_data = d;
    cyc();
    pre_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    miss_end = 0;
    pre_we   = 1'b0;
    pre_idx  = 8'd0;
    pre_data = 32'd0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("rst stall",  {31'd0, stall}, 32'd0);
    chk("rst rd_req", {31'd0, cache_rd_req}, 32'd0);
    chk("rst wr_req", {31'd0, cache_wr_req}, 32'd0);
    chk("rst rdata",  rdata, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
`ifdef LSU_PERF_CNT_EN
    chk("rst perf_access", perf_access_cnt, 32'd0);
    chk("rst perf_miss",   perf_miss_cnt,   32'd0);
`endif

    // 1: cold lw 0x40 misses for 3 cycles, then hits; repeat hits immediately.
    preload(32'h40, 32'hDEADBEEF);
    miss_end = cyc_cnt + 3;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t1 cold stall", {31'd0, stall}, 32'd1);
      cyc();
    end
    chk("t1 fill stall",   {31'd0, stall}, 32'd0);
    chk("t1 fill rdata",   rdata, 32'hDEADBEEF);
    cyc();
    chk("t1 repeat stall", {31'd0, stall}, 32'd0);
    chk("t1 repeat rdata", rdata, 32'hDEADBEEF);
    cyc();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
`ifdef LSU_PERF_CNT_EN
    chk("t1 perf_access", perf_access_cnt, 32'd2);
    chk("t1 perf_miss",   perf_miss_cnt,   32'd1);
`endif

    // 2: sign/zero extension from word 0x80FF1234.
    preload(32'h40, 32'h80FF1234);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h43, 32'd0);
    chk("t2 lb 0x43",  rdata, 32'hFFFFFF80);
    chk("t2 lb stall", {31'd0, stall}, 32'd0);
    cyc();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h43, 32'd0);
    chk("t2 lbu 0x43", rdata, 32'h00000080);
    cyc();
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h42, 32'd0);
    chk("t2 lh 0x42",  rdata, 32'hFFFF80FF);
    cyc();
    drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h40, 32'd0);
    chk("t2 lhu 0x40", rdata, 32'h00001234);
    cyc();
    drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h40, 32'd0);
    chk("t2 size3 word", rdata, 32'h80FF1234);
    cyc();

    // 3: sh 0xBEEF to 0x42 on a hit: one stall cycle, then the merged write.
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    preload(32'h40, 32'h11223344);
    drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF);
    chk("t3 rd stall",   {31'd0, stall}, 32'd1);
    chk("t3 rd rd_req",  {31'd0, cache_rd_req}, 32'd1);
    chk("t3 rd wr_req",  {31'd0, cache_wr_req}, 32'd0);
    cyc();
    chk("t3 wr stall",   {31'd0, stall}, 32'd0);
    chk("t3 wr wr_req",  {31'd0, cache_wr_req}, 32'd1);
    chk("t3 wr rd_req",  {31'd0, cache_rd_req}, 32'd0);
    chk("t3 wr data",    cache_wr_data, 32'hBEEF3344);
    chk("t3 wr addr",    cache_addr, 32'h00000040);
    cyc();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    chk("t3 lw after sh", rdata, 32'hBEEF3344);
    cyc();

    // 4: sb 0xAA to 0x201 with a long miss (victim swap-out + swap-in).
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    preload(32'h200, 32'h55667788);
    miss_end = cyc_cnt + 5;
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AA);
    for (int i = 0; i < 6; i++) begin
      chk("t4 miss stall", {31'd0, stall}, 32'd1);
      cyc();
    end
    chk("t4 rmw wr_req", {31'd0, cache_wr_req}, 32'd1);
    chk("t4 rmw data",   cache_wr_data, 32'h5566AA88);
    chk("t4 rmw stall",  {31'd0, stall}, 32'd0);
    cyc();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    chk("t4 lw 0x200", rdata, 32'h5566AA88);
    cyc();

    // 5: misaligned accesses are dropped.
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h42, 32'd0);
    chk("t5 lw misalign", {31'd0, misalign}, 32'd1);
    chk("t5 lw rd_req",   {31'd0, cache_rd_req}, 32'd0);
    chk("t5 lw wr_req",   {31'd0, cache_wr_req}, 32'd0);
    chk("t5 lw stall",    {31'd0, stall}, 32'd0);
    chk("t5 lw rdata",    rdata, 32'd0);
    cyc();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h41, 32'h00001234);
    chk("t5 sh misalign", {31'd0, misalign}, 32'd1);
    chk("t5 sh rd_req",   {31'd0, cache_rd_req}, 32'd0);
    chk("t5 sh wr_req",   {31'd0, cache_wr_req}, 32'd0);
    chk("t5 sh stall",    {31'd0, stall}, 32'd0);
    cyc();

    // 6: reset asserted while RMW_WR is stalled abandons the write.
    drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h42, 32'h00005555);
    chk("t6 rd_req", {31'd0, cache_rd_req}, 32'd1);
    cyc();
    miss_end = cyc_cnt + 4;
    #1;
    chk("t6 rmw wr_req", {31'd0, cache_wr_req}, 32'd1);
    chk("t6 rmw stall",  {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst wr_req", {31'd0, cache_wr_req}, 32'd0);
    chk("t6 rst rd_req", {31'd0, cache_rd_req}, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    miss_end = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6 idle stall",  {31'd0, stall}, 32'd0);
    chk("t6 idle wr_req", {31'd0, cache_wr_req}, 32'd0);
`ifdef LSU_PERF_CNT_EN
    chk("t6 perf_access", perf_access_cnt, 32'd0);
    chk("t6 perf_miss",   perf_miss_cnt,   32'd0);
`endif
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    chk("t6 word untouched", rdata, 32'hBEEF3344);
    cyc();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
